// File: rtl/cam_pkg.sv
// cam_pkg: shared defaults and the search result type for cam_array.
package cam_pkg;
  localparam int CAM_DATA_W = 8;
  localparam int CAM_DEPTH = 8;
  localparam int CAM_ADDR_W = $clog2(CAM_DEPTH);
  typedef struct packed {
    logic hit;
    logic [CAM_ADDR_W-1:0] addr;
    logic [CAM_DEPTH-1:0] match;
  } cam_result_t;
endpackage

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-index priority encoder with hit flag, purely combinational.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int N = CAM_DEPTH,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         hit
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = vec[i] ? W'(i) : idx;
    hit = |vec;
  end
endmodule

// File: rtl/cam_array.sv
// cam_array: two-stage pipelined CAM with per-entry valid bits.
// Define CAM_TERNARY_EN to add per-entry don't-care masks (wr_mask port).
module cam_array
  import cam_pkg::*;
#(
  parameter int DATA_W = CAM_DATA_W,
  parameter int DEPTH  = CAM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef CAM_TERNARY_EN
  input  logic [DATA_W-1:0] wr_mask,
`endif
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              srch_req,
  input  logic [DATA_W-1:0] srch_key,
  output logic              srch_valid,
  output logic              srch_hit,
  output logic [ADDR_W-1:0] srch_addr,
  output logic [DEPTH-1:0]  srch_match,
  output logic [DEPTH-1:0]  status,
  output logic [ADDR_W:0]   count,
  output logic              full
);
  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DATA_W-1:0] entry_d [DEPTH];
`ifdef CAM_TERNARY_EN
  logic [DATA_W-1:0] mask_q [DEPTH];
  logic [DATA_W-1:0] mask_d [DEPTH];
`endif
  logic [DEPTH-1:0]  valid_q, valid_d, match_q, match_d, srch_match_q, srch_match_d;
  logic              req_q, srch_valid_q, srch_hit_q, srch_hit_d, enc_hit;
  logic [ADDR_W-1:0] srch_addr_q, srch_addr_d, enc_addr;
  logic [ADDR_W:0]   count_q, count_d;

  cam_prio_enc #(.N(DEPTH), .W(ADDR_W)) u_enc (.vec(match_q), .idx(enc_addr), .hit(enc_hit));

  // Stage 1 compares against pre-edge contents; clear is applied after write so it wins.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
`ifdef CAM_TERNARY_EN
    mask_d = mask_q;
`endif
    match_d = '0;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i)) begin
        entry_d[i] = wr_data;
        valid_d[i] = 1'b1;
`ifdef CAM_TERNARY_EN
        mask_d[i] = wr_mask;
`endif
      end
      if (clr_en && clr_addr == ADDR_W'(i)) valid_d[i] = 1'b0;
`ifdef CAM_TERNARY_EN
      match_d[i] = valid_q[i] & (((entry_q[i] ^ srch_key) & mask_q[i]) == '0);
`else
      match_d[i] = valid_q[i] & (entry_q[i] == srch_key);
`endif
      count_d = count_d + (ADDR_W+1)'(valid_d[i]);
    end
    srch_match_d = req_q ? match_q : srch_match_q;
    srch_hit_d = req_q ? enc_hit : srch_hit_q;
    srch_addr_d = req_q ? enc_addr : srch_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '{default: '0};
`ifdef CAM_TERNARY_EN
      mask_q <= '{default: '1};
`endif
      valid_q <= '0;
      match_q <= '0;
      req_q <= 1'b0;
      srch_valid_q <= 1'b0;
      srch_hit_q <= 1'b0;
      srch_addr_q <= '0;
      srch_match_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
`ifdef CAM_TERNARY_EN
      mask_q <= mask_d;
`endif
      valid_q <= valid_d;
      match_q <= match_d;
      req_q <= srch_req;
      srch_valid_q <= req_q;
      srch_hit_q <= srch_hit_d;
      srch_addr_q <= srch_addr_d;
      srch_match_q <= srch_match_d;
      count_q <= count_d;
    end
  end

  assign srch_valid = srch_valid_q;
  assign srch_hit = srch_hit_q;
  assign srch_addr = srch_addr_q;
  assign srch_match = srch_match_q;
  assign status = valid_q;
  assign count = count_q;
  assign full = count_q == (ADDR_W+1)'(DEPTH);
endmodule

// File: tb/tb_cam_array.sv
// tb_cam_array: directed and randomized checks of cam_array against a table-level reference model.
module tb_cam_array;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, clr_en = 1'b0, srch_req = 1'b0;
  logic [2:0] wr_addr = '0, clr_addr = '0;
  logic [7:0] wr_data = '0, srch_key = '0;
`ifdef CAM_TERNARY_EN
  logic [7:0] wr_mask = 8'hFF;
`endif
  logic       srch_valid, srch_hit, full;
  logic [2:0] srch_addr;
  logic [7:0] srch_match, status;
  logic [3:0] count;

  cam_array dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef CAM_TERNARY_EN
    .wr_mask(wr_mask),
`endif
    .clr_en(clr_en), .clr_addr(clr_addr), .srch_req(srch_req), .srch_key(srch_key),
    .srch_valid(srch_valid), .srch_hit(srch_hit), .srch_addr(srch_addr),
    .srch_match(srch_match), .status(status), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic hit; logic [2:0] addr; logic [7:0] match;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, edge_n = 0;
  logic [7:0] m_data [8];
  logic [7:0] m_mask [8];
  logic [7:0] m_vld;
  logic       e_valid, l_hit;
  logic [2:0] l_addr;
  logic [7:0] l_match;

  function automatic exp_t model_search(input logic [7:0] key);
    exp_t e;
    e.match = '0;
    for (int i = 0; i < 8; i++) e.match[i] = m_vld[i] && (((m_data[i] ^ key) & m_mask[i]) == 8'h00);
    e.hit = e.match != 0;
    e.addr = 0;
    for (int i = 0; i < 8; i++) if (e.match[i]) begin e.addr = 3'(i); break; end
    e.due = 0;
    return e;
  endfunction

  function automatic int pop_count(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic idle();
    wr_en = 0; clr_en = 0; srch_req = 0;
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 8; i++) begin m_data[i] = 0; m_mask[i] = 8'hFF; end
    m_vld = 0; e_valid = 0; l_hit = 0; l_addr = 0; l_match = 0;
  endtask

  // One clock edge: the model samples the inputs exactly as the DUT does, then we settle at negedge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    edge_n++;
    if (rst_n) begin
      if (srch_req) begin e = model_search(srch_key); e.due = edge_n + 1; q.push_back(e); end
      if (wr_en) begin
        m_data[wr_addr] = wr_data; m_vld[wr_addr] = 1;
`ifdef CAM_TERNARY_EN
        m_mask[wr_addr] = wr_mask;
`endif
      end
      if (clr_en) m_vld[clr_addr] = 0;
    end
    e_valid = 0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      e_valid = 1; l_hit = e.hit; l_addr = e.addr; l_match = e.match;
    end
    @(negedge clk);
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    idle(); wr_en = 1; wr_addr = a; wr_data = d; tick(); idle();
  endtask

  task automatic search(input logic [7:0] k);
    idle(); srch_req = 1; srch_key = k; tick(); idle(); tick();
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; model_clear();
    #3;
    n_cmp++; if (srch_valid !== 0) begin n_bad++; $display("FAIL reset_valid got %b want 0", srch_valid); end
    n_cmp++; if ({srch_hit, srch_addr, srch_match} !== 12'h0) begin n_bad++; $display("FAIL reset_result got %b/%0d/%h want 0/0/00", srch_hit, srch_addr, srch_match); end
    n_cmp++; if ({status, count, full} !== 13'h0) begin n_bad++; $display("FAIL reset_status got %h/%0d/%b want 00/0/0", status, count, full); end
    @(negedge clk); rst_n = 1;
    search(8'h00);
    n_cmp++; if ({srch_valid, srch_hit, srch_addr, srch_match} !== 13'h1000) begin n_bad++; $display("FAIL first_miss got v%b h%b a%0d m%h want v1 h0 a0 m00", srch_valid, srch_hit, srch_addr, srch_match); end
  endtask

  task automatic test_table();
    logic [7:0] vals [8] = '{8'hAB, 8'hCB, 8'hAC, 8'hCC, 8'hAD, 8'hDB, 8'hDC, 8'hFB};
    for (int i = 0; i < 8; i++) write(3'(i), vals[i]);
    search(8'hAD);
    n_cmp++; if ({srch_valid, srch_hit, srch_addr, srch_match} !== {1'b1, 1'b1, 3'd4, 8'h10}) begin n_bad++; $display("FAIL table_ad got v%b h%b a%0d m%h want v1 h1 a4 m10", srch_valid, srch_hit, srch_addr, srch_match); end
    n_cmp++; if ({count, full} !== {4'd8, 1'b1}) begin n_bad++; $display("FAIL table_full got %0d/%b want 8/1", count, full); end
    write(3'd6, 8'hAD);
    search(8'hAD);
    n_cmp++; if ({srch_addr, srch_match} !== {3'd4, 8'h50}) begin n_bad++; $display("FAIL dual_hit got a%0d m%h want a4 m50", srch_addr, srch_match); end
    idle(); clr_en = 1; clr_addr = 4; tick(); idle();
    search(8'hAD);
    n_cmp++; if ({srch_hit, srch_addr, srch_match, count, full} !== {1'b1, 3'd6, 8'h40, 4'd7, 1'b0}) begin n_bad++; $display("FAIL after_clear got h%b a%0d m%h c%0d f%b want h1 a6 m40 c7 f0", srch_hit, srch_addr, srch_match, count, full); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] keys [4] = '{8'hCB, 8'hAD, 8'h77, 8'hFB};
    int pulses = 0;
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c < 4) begin srch_req = 1; srch_key = keys[c]; end
      tick();
      pulses += int'(srch_valid);
      n_cmp++; if ({srch_valid, srch_hit, srch_addr, srch_match} !== {e_valid, l_hit, l_addr, l_match}) begin n_bad++; $display("FAIL b2b_%0d got v%b h%b a%0d m%h want v%b h%b a%0d m%h", c, srch_valid, srch_hit, srch_addr, srch_match, e_valid, l_hit, l_addr, l_match); end
    end
    idle();
    n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
  endtask

  task automatic test_same_edge();
    idle(); wr_en = 1; wr_addr = 2; wr_data = 8'h55; srch_req = 1; srch_key = 8'h55; tick();
    idle(); srch_req = 1; srch_key = 8'h55; tick();
    n_cmp++; if ({srch_valid, srch_hit} !== 2'b10) begin n_bad++; $display("FAIL same_edge_miss got v%b h%b want v1 h0", srch_valid, srch_hit); end
    idle(); tick();
    n_cmp++; if ({srch_valid, srch_hit, srch_addr} !== {1'b1, 1'b1, 3'd2}) begin n_bad++; $display("FAIL next_edge_hit got v%b h%b a%0d want v1 h1 a2", srch_valid, srch_hit, srch_addr); end
    idle(); wr_en = 1; wr_addr = 3; wr_data = 8'h66; clr_en = 1; clr_addr = 3; tick(); idle();
    n_cmp++; if (status[3] !== 1'b0) begin n_bad++; $display("FAIL wr_clr_same got status[3]=%b want 0", status[3]); end
    idle(); wr_en = 1; wr_addr = 3; wr_data = 8'h66; clr_en = 1; clr_addr = 2; tick(); idle();
    n_cmp++; if (status[3:2] !== 2'b10) begin n_bad++; $display("FAIL wr_clr_diff got status[3:2]=%b want 10", status[3:2]); end
  endtask

  task automatic test_reset_mid();
    idle(); srch_req = 1; srch_key = 8'h66; tick(); idle();
    rst_n = 0; model_clear();
    #1;
    n_cmp++; if ({status, count, full} !== 13'h0) begin n_bad++; $display("FAIL mid_reset_status got %h/%0d/%b want 00/0/0", status, count, full); end
    for (int c = 0; c < 3; c++) begin
      if (c == 1) rst_n = 1;
      tick();
      n_cmp++; if (srch_valid !== 1'b0) begin n_bad++; $display("FAIL flush_%0d got srch_valid %b want 0", c, srch_valid); end
    end
  endtask

`ifdef CAM_TERNARY_EN
  task automatic test_ternary();
    idle(); wr_en = 1; wr_addr = 1; wr_data = 8'hA0; wr_mask = 8'hF0; tick(); idle(); wr_mask = 8'hFF;
    search(8'hA7);
    n_cmp++; if ({srch_valid, srch_hit, srch_addr} !== {1'b1, 1'b1, 3'd1}) begin n_bad++; $display("FAIL tern_hit got v%b h%b a%0d want v1 h1 a1", srch_valid, srch_hit, srch_addr); end
    search(8'hB7);
    n_cmp++; if ({srch_valid, srch_hit} !== 2'b10) begin n_bad++; $display("FAIL tern_miss got v%b h%b want v1 h0", srch_valid, srch_hit); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 3'($urandom); wr_data = 8'(8'h30 + $urandom_range(0, 3));
      clr_en = ($urandom_range(0, 3) == 0); clr_addr = 3'($urandom);
      srch_req = ($urandom_range(0, 3) != 0); srch_key = 8'(8'h30 + $urandom_range(0, 4));
`ifdef CAM_TERNARY_EN
      wr_mask = ($urandom_range(0, 2) == 0) ? 8'hFC : 8'hFF;
`endif
      tick();
      n_cmp++; if ({srch_valid, srch_hit, srch_addr, srch_match} !== {e_valid, l_hit, l_addr, l_match}) begin n_bad++; $display("FAIL rand_result_%0d got v%b h%b a%0d m%h want v%b h%b a%0d m%h", c, srch_valid, srch_hit, srch_addr, srch_match, e_valid, l_hit, l_addr, l_match); end
      n_cmp++; if ({status, count, full} !== {m_vld, 4'(pop_count(m_vld)), pop_count(m_vld) == 8}) begin n_bad++; $display("FAIL rand_status_%0d got %h/%0d/%b want %h/%0d/%b", c, status, count, full, m_vld, pop_count(m_vld), pop_count(m_vld) == 8); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_table();
    test_back_to_back();
    test_same_edge();
    test_reset_mid();
`ifdef CAM_TERNARY_EN
    test_ternary();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cam_array.md
# cam_array

Clocked, parametrised content-addressable memory, the successor to the 8×8 combinational `CAM`. It holds `DEPTH` entries of `DATA_W` bits with per-entry valid bits, written by address and searched by content through a two-stage pipeline. Each search returns a match vector, a hit flag and the lowest matching address. It sits between the lookup requester and the table-management logic and accepts one search per cycle.

## Interface
Parameters:
- `DATA_W`, default 8: entry and key width.
- `DEPTH`, default 8: number of entries, at least 2.
- `ADDR_W`, default `$clog2(DEPTH)`: address width. Derived; do not override.

Ports:
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: write `wr_data` to `wr_addr` and set that entry's valid bit.
- `wr_addr`  in  `ADDR_W`: write address. Values ≥ `DEPTH` are ignored.
- `wr_data`  in  `DATA_W`: write data.
- `clr_en`  in  1: clear the valid bit of entry `clr_addr`.
- `clr_addr`  in  `ADDR_W`: clear address. Values ≥ `DEPTH` are ignored.
- `srch_req`  in  1: search request.
- `srch_key`  in  `DATA_W`: search key.
- `srch_valid`  out  1: one-cycle strobe; the result outputs are valid.
- `srch_hit`  out  1: at least one valid entry matched.
- `srch_addr`  out  `ADDR_W`: lowest matching index; 0 when there is no hit.
- `srch_match`  out  `DEPTH`: per-entry match vector; bit i is entry i.
- `status`  out  `DEPTH`: valid bits of all entries, registered.
- `count`  out  `ADDR_W+1`: number of valid entries.
- `full`  out  1: `count == DEPTH`.

## Operation
- Storage: `DEPTH` data registers, one valid bit per entry.
- Write: on an edge with `wr_en`, `entry[wr_addr] <= wr_data` and `valid[wr_addr] <= 1`.
- Clear: on an edge with `clr_en`, `valid[clr_addr] <= 0`. Entry data is retained.
- Write and clear to the same address on the same edge: clear wins, and the data is still written.
- Write and clear to different addresses on the same edge: both take effect.
- Stage 1 (edge where `srch_req` is sampled):
  - `match_q[i] <= valid[i] & (entry[i] == srch_key)`, using pre-edge entry and valid state.
  - `req_q <= srch_req`.
- Stage 2 (next edge):
  - `srch_valid <= req_q`.
  - `srch_match <= match_q`.
  - `srch_hit <= |match_q`.
  - `srch_addr <=` index of the lowest set bit of `match_q`, or 0 if none.
- When `srch_valid` is low, the result outputs hold their last values.
- No backpressure. Searches are fully pipelined, one per cycle.
- `count` and `status` are registered from the post-edge valid state, so they update on the same edge as the write or clear.
- Writing an already-valid entry does not change `count`.

## Timing
- Search latency is 2 cycles: `srch_req` sampled at edge E produces `srch_valid` high for the cycle after edge E+1.
- Write or clear at edge E is not visible to a search sampled at E. It is visible to a search sampled at E+1.
- `status`, `count` and `full` are updated on the edge of the write or clear.
- Reset, asynchronous on `rst_n` low:
  - All valid bits, entries and `match_q` go to 0.
  - `req_q` and `srch_valid` go to 0.
  - `srch_hit`, `srch_addr`, `srch_match`, `status` and `count` go to 0; `full` goes to 0.
- Reset mid-search flushes the in-flight search; no `srch_valid` is produced for it.
- First search after release returns a miss.

## Configuration
- `CAM_TERNARY_EN` defined:
  - Adds input port `wr_mask` [`DATA_W`], stored per entry on write.
  - Stage-1 match becomes `valid[i] & (((entry[i] ^ srch_key) & mask[i]) == 0)`; a mask bit of 0 means don't-care.
  - Reset value of the masks is all ones.
- `CAM_TERNARY_EN` undefined: no `wr_mask` port and no mask storage; binary exact match only.

## Structure
- Shared package `cam_pkg`: `DATA_W` and `DEPTH` defaults, plus a `cam_result_t` struct holding hit, addr and match.
- Sub-module `cam_prio_enc`: parametrised lowest-index priority encoder from `DEPTH` bits to `ADDR_W` bits plus a hit flag. Purely combinational, used in stage 2.

## Test plan
- Write 0xAB, 0xCB, 0xAC, 0xCC, 0xAD, 0xDB, 0xDC, 0xFB to addresses 0–7, then search 0xAD -> two cycles later `srch_valid=1`, `srch_hit=1`, `srch_addr=4`, `srch_match=8'h10`; `count=8`, `full=1`.
- Additionally write 0xAD to address 6, then search 0xAD -> `srch_match=8'h50`, `srch_addr=4`. Clear entry 4 and search again -> `srch_addr=6`, `count=7`.
- Search 0x00 after reset -> `srch_hit=0`, `srch_addr=0`, `srch_match=0`. Searches on 4 consecutive cycles -> 4 consecutive `srch_valid` pulses, in order.
- Write 0x55 to address 2 and search 0x55 on the same edge -> miss. A search one cycle later -> hit at address 2. Write and clear of address 3 on the same edge -> `status[3]=0`.
- Assert `rst_n=0` one cycle after `srch_req` -> no `srch_valid` pulse; `status=0` and `count=0` immediately.
- `CAM_TERNARY_EN`: write 0xA0 with mask 0xF0 to address 1, then search 0xA7 -> hit at address 1. Search 0xB7 -> miss.
